// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Request as captured at accept time.
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              sgn;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Reserved size, misalignment, or word index past the end of RAM.
    function automatic logic req_error(size_e size, logic [DATA_W-1:0] addr,
                                       int unsigned mem_words);
        logic err;
        case (size)
            SZ_HALF: err = addr[0];
            SZ_WORD: err = |addr[1:0];
            SZ_RSVD: err = 1'b1;
            default: err = 1'b0;
        endcase
        if (32'(addr >> WORD_SHIFT) >= mem_words) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-RAM signals of the load/store unit.
interface load_store_unit_if
    import lsu_pkg::*;
();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Environment side: the core plus the RAM.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c,
    output logic [DATA_W-1:0] merged_c
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte and halfword of the word.
    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend the loaded lane and splice the store lane into the old word.
    always_comb begin
        rdata_c  = '0;
        merged_c = word;
        case (size)
            SZ_BYTE: begin
                rdata_c = {{24{sgn & byte_lane[7]}}, byte_lane};
                case (offset)
                    2'd0:    merged_c[7:0]   = wdata[7:0];
                    2'd1:    merged_c[15:8]  = wdata[7:0];
                    2'd2:    merged_c[23:16] = wdata[7:0];
                    default: merged_c[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                rdata_c = {{16{sgn & half_lane[15]}}, half_lane};
                if (offset[1]) begin
                    merged_c[31:16] = wdata[15:0];
                end else begin
                    merged_c[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                rdata_c  = word;
                merged_c = wdata;
            end
            default: begin
                rdata_c  = '0;
                merged_c = word;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core requests to word-wide RAM cycles, read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    state_e                  state, state_n;
    lsu_req_t                req_q, req_n;
    logic [DATA_WIDTH-1:0]   rd_word, rd_word_n;

    logic                    req_ready_q,  req_ready_n;
    logic                    resp_valid_q, resp_valid_n;
    logic                    resp_error_q, resp_error_n;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_n;
    logic [DATA_WIDTH-1:0]   mem_addr_q,   mem_addr_n;
    logic [DATA_WIDTH-1:0]   mem_wdata_q,  mem_wdata_n;
    logic                    mem_we_q,     mem_we_n;
    logic                    mem_re_q,     mem_re_n;

    logic [DATA_WIDTH-1:0]   align_word;
    logic [DATA_WIDTH-1:0]   load_data_c;
    logic [DATA_WIDTH-1:0]   merged_word_c;
    logic                    in_err_c;
    size_e                   in_size_c;

    // RAM data is only meaningful during READ; elsewhere use the captured word.
    assign align_word = (state == READ) ? bus.mem_rdata : rd_word;
    assign in_size_c  = size_e'(bus.req_size);
    assign in_err_c   = req_error(in_size_c, bus.req_addr, MEM_WORDS);

    lsu_lane_align u_align (
        .word     (align_word),
        .offset   (req_q.addr[1:0]),
        .size     (req_q.size),
        .sgn      (req_q.sgn),
        .wdata    (req_q.wdata),
        .rdata_c  (load_data_c),
        .merged_c (merged_word_c)
    );

    // State, captured request and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_q        <= '0;
            rd_word      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state        <= state_n;
            req_q        <= req_n;
            rd_word      <= rd_word_n;
            req_ready_q  <= req_ready_n;
            resp_valid_q <= resp_valid_n;
            resp_error_q <= resp_error_n;
            resp_rdata_q <= resp_rdata_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            mem_we_q     <= mem_we_n;
            mem_re_q     <= mem_re_n;
        end
    end

    // Next state and next registered outputs for the cycle being entered.
    always_comb begin
        state_n      = state;
        req_n        = req_q;
        rd_word_n    = rd_word;
        req_ready_n  = 1'b0;
        resp_valid_n = 1'b0;
        resp_error_n = 1'b0;
        resp_rdata_n = '0;
        mem_addr_n   = '0;
        mem_wdata_n  = '0;
        mem_we_n     = 1'b0;
        mem_re_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    req_n.we    = bus.req_we;
                    req_n.size  = in_size_c;
                    req_n.sgn   = bus.req_signed;
                    req_n.addr  = bus.req_addr;
                    req_n.wdata = bus.req_wdata;
                    if (in_err_c) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                    end else if (bus.req_we && in_size_c == SZ_WORD) begin
                        state_n     = WRITE;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_n = bus.req_wdata;
                    end else begin
                        state_n    = READ;
                        mem_re_n   = 1'b1;
                        mem_addr_n = {bus.req_addr[31:2], 2'b00};
                    end
                end else begin
                    req_ready_n = 1'b1;
                end
            end
            READ: begin
                rd_word_n = bus.mem_rdata;
                if (req_q.we) begin
                    state_n     = WRITE;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {req_q.addr[31:2], 2'b00};
                    mem_wdata_n = merged_word_c;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = load_data_c;
                end
            end
            WRITE: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word RAM model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    load_store_unit_if bus ();

    load_store_unit #(.DATA_WIDTH(32), .MEM_WORDS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read while enabled, write on the clock edge.
    logic [31:0] ram [32] = '{default: 32'h0};
    assign bus.mem_rdata = bus.mem_re ? ram[bus.mem_addr[6:2]] : 32'hDEADBEEF;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[6:2]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response, checking the RAM cycles on the way.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_re, input int exp_we, input logic [31:0] exp_wdata);
        int n_re = 0, n_we = 0, lat = 0, both = 0;
        logic [31:0] w_data = 32'h0, a_seen = 32'h0;
        @(negedge clk);
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (bus.mem_re) begin n_re++; a_seen = bus.mem_addr; end
            if (bus.mem_we) begin n_we++; w_data = bus.mem_wdata; a_seen = bus.mem_addr; end
            if (bus.mem_re && bus.mem_we) both++;
            if (bus.resp_valid) begin lat = i; break; end
            @(posedge clk); #1;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, " error"}, 32'(bus.resp_error), 32'(exp_err));
        check({tag, " re_cycles"}, 32'(n_re), 32'(exp_re));
        check({tag, " we_cycles"}, 32'(n_we), 32'(exp_we));
        check({tag, " re_we_overlap"}, 32'(both), 32'd0);
        if (exp_re + exp_we > 0) check({tag, " mem_addr"}, a_seen, {addr[31:2], 2'b00});
        if (exp_we > 0) check({tag, " wdata"}, w_data, exp_wdata);
        @(posedge clk); #1;
        check({tag, " resp_pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // Reset state
        #12;
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst mem_re", 32'(bus.mem_re), 32'd0);
        check("rst mem_we", 32'(bus.mem_we), 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst resp_rdata", bus.resp_rdata, 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);

        // Word store, then loads of each lane
        do_req("sw08", 1, 2'b10, 0, 32'h08, 32'h823456F0, 2, 32'h0, 0, 0, 1, 32'h823456F0);
        do_req("lb08", 0, 2'b00, 1, 32'h08, 32'h0, 2, 32'hFFFFFFF0, 0, 1, 0, 32'h0);
        do_req("lbu08", 0, 2'b00, 0, 32'h08, 32'h0, 2, 32'h000000F0, 0, 1, 0, 32'h0);
        do_req("lh0A", 0, 2'b01, 1, 32'h0A, 32'h0, 2, 32'hFFFF8234, 0, 1, 0, 32'h0);
        do_req("lhu0A", 0, 2'b01, 0, 32'h0A, 32'h0, 2, 32'h00008234, 0, 1, 0, 32'h0);
        do_req("lw08", 0, 2'b10, 0, 32'h08, 32'h0, 2, 32'h823456F0, 0, 1, 0, 32'h0);
        do_req("lb0B", 0, 2'b00, 1, 32'h0B, 32'h0, 2, 32'hFFFFFF82, 0, 1, 0, 32'h0);
        do_req("lh08", 0, 2'b01, 1, 32'h08, 32'h0, 2, 32'h000056F0, 0, 1, 0, 32'h0);

        // Sub-word stores by read-modify-write
        do_req("sb09", 1, 2'b00, 0, 32'h09, 32'h000000AA, 3, 32'h0, 0, 1, 1, 32'h8234AAF0);
        do_req("lw08b", 0, 2'b10, 0, 32'h08, 32'h0, 2, 32'h8234AAF0, 0, 1, 0, 32'h0);
        do_req("sh0A", 1, 2'b01, 0, 32'h0A, 32'hFFFF1357, 3, 32'h0, 0, 1, 1, 32'h1357AAF0);

        // Error cases, plus the last valid word
        do_req("lw0A", 0, 2'b10, 0, 32'h0A, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
        do_req("lh05", 0, 2'b01, 1, 32'h05, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
        do_req("lw80", 0, 2'b10, 0, 32'h80, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
        do_req("rsvd", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
        do_req("sw80", 1, 2'b10, 0, 32'h80, 32'h12345678, 1, 32'h0, 1, 0, 0, 32'h0);
        do_req("sw7C", 1, 2'b10, 0, 32'h7C, 32'h0BADF00D, 2, 32'h0, 0, 0, 1, 32'h0BADF00D);
        do_req("lw7C", 0, 2'b10, 0, 32'h7C, 32'h0, 2, 32'h0BADF00D, 0, 1, 0, 32'h0);

        // Reset in the middle of a sub-word store
        do_req("sw0C", 1, 2'b10, 0, 32'h0C, 32'hCAFEBABE, 2, 32'h0, 0, 0, 1, 32'hCAFEBABE);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0C; bus.req_wdata = 32'h00001234;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort in_read", 32'(bus.mem_re), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort mem_re", 32'(bus.mem_re), 32'd0);
        check("abort mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk); reset = 1'b0;
        begin
            int late = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (bus.mem_we || bus.resp_valid) late++;
            end
            check("abort no_activity", 32'(late), 32'd0);
        end
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        do_req("lw0C", 0, 2'b10, 0, 32'h0C, 32'h0, 2, 32'hCAFEBABE, 0, 1, 0, 32'h0);

        // Back-to-back loads with req_valid held high
        do_req("sw00", 1, 2'b10, 0, 32'h00, 32'h11111111, 2, 32'h0, 0, 0, 1, 32'h11111111);
        do_req("sw04", 1, 2'b10, 0, 32'h04, 32'h22222222, 2, 32'h0, 0, 0, 1, 32'h22222222);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h00;
        @(posedge clk); #1;
        bus.req_addr = 32'h04;
        check("b2b c1 ready", 32'(bus.req_ready), 32'd0);
        check("b2b c1 re", 32'(bus.mem_re), 32'd1);
        @(posedge clk); #1;
        check("b2b c2 ready", 32'(bus.req_ready), 32'd0);
        check("b2b c2 resp", 32'(bus.resp_valid), 32'd1);
        check("b2b c2 data", bus.resp_rdata, 32'h11111111);
        @(posedge clk); #1;
        check("b2b c3 ready", 32'(bus.req_ready), 32'd1);
        check("b2b c3 re", 32'(bus.mem_re), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("b2b c4 re", 32'(bus.mem_re), 32'd1);
        check("b2b c4 addr", bus.mem_addr, 32'h04);
        @(posedge clk); #1;
        check("b2b c5 resp", 32'(bus.resp_valid), 32'd1);
        check("b2b c5 data", bus.resp_rdata, 32'h22222222);
        @(posedge clk); #1;
        check("b2b c6 ready", 32'(bus.req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Hard stop in case the run never reaches its end.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
